// File: rtl/sobel_stream_ctrl_pkg.sv
// Shared types and default sizing for the streaming Sobel engine.
package sobel_pkg;

  localparam int DEF_PIXEL_WIDTH  = 8;
  localparam int DEF_IMAGE_WIDTH  = 64;
  localparam int DEF_IMAGE_HEIGHT = 48;

  localparam int COL_BITS   = $clog2(DEF_IMAGE_WIDTH);
  localparam int ROW_BITS   = $clog2(DEF_IMAGE_HEIGHT);
  localparam int MAX_PX_VAL = (1 << DEF_PIXEL_WIDTH) - 1;

  // Frame controller states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // 3x3 window, [row][col] with row 0 at the top and col 0 on the left.
  typedef logic [2:0][2:0][DEF_PIXEL_WIDTH-1:0] sobel_matrix;

endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// Pixel stream in / result stream out, both valid/ready.
interface sobel_stream_ctrl_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0] in_px_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [PIXEL_WIDTH-1:0] out_px_o;
  logic                   out_valid_o;
  logic                   out_ready_i;

  modport master (
    output in_px_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_px_o, out_valid_o
  );

  modport slave (
    input  in_px_i, in_valid_i, out_ready_i,
    output in_ready_o, out_px_o, out_valid_o
  );
endinterface

// File: rtl/sobel_core.sv
// Combinational Sobel gradient and saturated L1 magnitude of a 3x3 window.
module sobel_core #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [2:0][2:0][PIXEL_WIDTH-1:0] i_win,
  output logic [PIXEL_WIDTH-1:0]           o_mag
);

  localparam int SW = PIXEL_WIDTH + 3;
  localparam logic [SW:0] MAX_EXT = {{(SW + 1 - PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

  logic signed [SW-1:0] w_p [3][3];
  logic signed [SW-1:0] w_gx;
  logic signed [SW-1:0] w_gy;
  logic        [SW-1:0] w_ax;
  logic        [SW-1:0] w_ay;
  logic        [SW:0]   w_sum;

  // Zero-extend every tap into the signed gradient width.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_p[r][c] = $signed({3'b000, i_win[r][c]});
  end

  assign w_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
              - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
  assign w_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
              - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);

  assign w_ax  = w_gx[SW-1] ? -w_gx : w_gx;
  assign w_ay  = w_gy[SW-1] ? -w_gy : w_gy;
  assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
  assign o_mag = (w_sum > MAX_EXT) ? '1 : w_sum[PIXEL_WIDTH-1:0];

endmodule

// File: rtl/sobel_line_buffer.sv
// Enable-gated shift delay: output is the sample written DEPTH enables ago.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Shift one position per enabled cycle; cleared on reset.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_en) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel: raster pixels in, interior magnitude/binary stream out.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 48,
  parameter bit BINARIZE_EN  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [PIXEL_WIDTH-1:0] threshold_i,
  sobel_stream_ctrl_if.slave     bus,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam logic [PIXEL_WIDTH-1:0] MAX_PX = '1;

  state_t                          r_state;
  logic [COL_W-1:0]                r_col;
  logic [ROW_W-1:0]                r_row;
  logic                            r_mode;
  logic [PIXEL_WIDTH-1:0]          r_thr;
  logic                            r_busy;
  logic                            r_done;
  logic [2:0][2:0][PIXEL_WIDTH-1:0] r_win;
  logic [PIXEL_WIDTH-1:0]          r_out_px;
  logic                            r_out_valid;

  logic [2:0][2:0][PIXEL_WIDTH-1:0] w_next;
  logic [PIXEL_WIDTH-1:0]          w_lb0;
  logic [PIXEL_WIDTH-1:0]          w_lb1;
  logic [PIXEL_WIDTH-1:0]          w_mag;
  logic [PIXEL_WIDTH-1:0]          w_res;
  logic                            w_accept;
  logic                            w_win_valid;
  logic                            w_last_px;

  assign bus.in_ready_o = (r_state == S_STREAM) && (!r_out_valid || bus.out_ready_i);
  assign w_accept       = bus.in_valid_i && bus.in_ready_o;
  // Border gate: needs two full rows above and two columns to the left in this row.
  assign w_win_valid    = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_last_px      = (r_row == ROW_W'(IMAGE_HEIGHT - 1)) && (r_col == COL_W'(IMAGE_WIDTH - 1));

  sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb0 (
    .clk_i(clk_i), .nreset_i(nreset_i), .i_en(w_accept), .i_din(bus.in_px_i), .o_dout(w_lb0)
  );

  sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb1 (
    .clk_i(clk_i), .nreset_i(nreset_i), .i_en(w_accept), .i_din(w_lb0), .o_dout(w_lb1)
  );

  // Window after this cycle's shift; the result is computed from it so it can load now.
  always_comb begin
    w_next = r_win;
    for (int r = 0; r < 3; r++) begin
      w_next[r][0] = r_win[r][1];
      w_next[r][1] = r_win[r][2];
    end
    w_next[0][2] = w_lb1;
    w_next[1][2] = w_lb0;
    w_next[2][2] = bus.in_px_i;
  end

  sobel_core #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_core (.i_win(w_next), .o_mag(w_mag));

  // Map magnitude to the frame's latched output mode.
  always_comb begin
    w_res = w_mag;
    if (r_mode) w_res = (w_mag >= r_thr) ? MAX_PX : '0;
  end

  // Window shifts once per accepted pixel.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) r_win <= '0;
    else if (w_accept) r_win <= w_next;
  end

  // Output register: load on completing pixel, hold under backpressure, clear on handshake.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_out_px    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && w_win_valid) begin
      r_out_px    <= w_res;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Frame FSM with raster counters, latched config and status flags.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_mode  <= 1'b0;
      r_thr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_state <= S_STREAM;
          r_mode  <= BINARIZE_EN && mode_i;
          r_thr   <= threshold_i;
          r_col   <= '0;
          r_row   <= '0;
          r_busy  <= 1'b1;
        end
        S_STREAM: if (w_accept) begin
          if (r_col == COL_W'(IMAGE_WIDTH - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
          if (w_last_px) r_state <= S_FLUSH;
        end
        S_FLUSH: if (r_out_valid && bus.out_ready_i) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_px_o    = r_out_px;
  assign bus.out_valid_o = r_out_valid;
  assign busy_o          = r_busy;
  assign frame_done_o    = r_done;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
module tb_sobel_stream_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk;
  logic       nreset;
  logic       start;
  logic       mode;
  logic [7:0] thr;
  logic       busy;
  logic       frame_done;

  sobel_stream_ctrl_if #(.PIXEL_WIDTH(8)) bus ();

  sobel_stream_ctrl #(
    .PIXEL_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BINARIZE_EN(1'b1)
  ) dut (
    .clk_i(clk), .nreset_i(nreset), .start_i(start), .mode_i(mode),
    .threshold_i(thr), .bus(bus), .busy_o(busy), .frame_done_o(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int hs_cyc  = -10;
  int out_cnt = 0;
  int done_cnt = 0;
  int img [H][W];
  int rnd_img [H][W];
  int exp_q [$];
  int got_q [$];
  int first_seq [$];

  task automatic check(input string name, input int got, input int expv);
    n_total++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  task automatic bail(input string name);
    n_total++;
    $display("FAIL %s: timed out", name);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  // Reference: direct Sobel on the stored image.
  function automatic int ref_out(input int r, input int c, input bit m, input int t);
    int gx, gy, mag;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (m) return (mag >= t) ? 255 : 0;
    return mag;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every output handshake; check frame_done timing.
  always @(negedge clk) begin
    if (nreset) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL extra_output: got px %0d with no expected entry", bus.out_px_o);
        end else begin
          check("out_px", int'(bus.out_px_o), exp_q.pop_front());
        end
        got_q.push_back(int'(bus.out_px_o));
        out_cnt++;
        hs_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        check("done_timing", cyc, hs_cyc + 1);
        check("frame_len", out_cnt, NOUT);
      end
    end
  end

  task automatic run_frame(input int pat, input bit m, input int t,
                           input bit bubbles, input bit bp, input int n_px);
    int d0, n, b;
    bit acc;
    logic [7:0] p0;
    if (pat == 0) foreach (img[r, c]) img[r][c] = 100;
    if (pat == 1) foreach (img[r, c]) img[r][c] = (c < 4) ? 0 : 200;
    if (pat == 2) foreach (img[r, c]) img[r][c] = 10 * c;
    if (pat == 3) foreach (img[r, c]) img[r][c] = rnd_img[r][c];
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++)
        exp_q.push_back(ref_out(r, c, m, t));
    out_cnt = 0;
    got_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; mode = m; thr = 8'(t);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int i = 0; i < n_px; i++) begin
      if (bubbles) begin
        b = 0;
        while ($urandom_range(1) == 1 && b < 8) begin
          bus.in_valid_i = 1'b0;
          @(posedge clk); #1;
          b++;
        end
      end
      bus.in_px_i    = 8'(img[i / W][i % W]);
      bus.in_valid_i = 1'b1;
      mode  = 1'($urandom_range(1));
      thr   = 8'($urandom_range(255));
      start = (i == 10);
      if (bp && i == 31) begin
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        p0 = bus.out_px_o;
        check("bp_valid_held", int'(bus.out_valid_o), 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", int'(bus.in_ready_o), 0);
          check("bp_px_stable", int'(bus.out_px_o), int'(p0));
          @(posedge clk); #1;
        end
        bus.out_ready_i = 1'b1;
      end
      n = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready_o;
        @(posedge clk); #1;
        n++;
      end while (!acc && n < 100);
      if (!acc) bail("pixel_accept");
    end
    bus.in_valid_i = 1'b0;
    start = 1'b0;
    if (n_px == W * H) begin
      n = 0;
      while (done_cnt == d0 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (done_cnt == d0) bail("frame_done_wait");
      repeat (3) @(posedge clk);
      #1;
      check("done_once", done_cnt - d0, 1);
      check("busy_idle", int'(busy), 0);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    nreset = 1'b0;
    start = 1'b0; mode = 1'b0; thr = 8'd0;
    bus.in_px_i = '0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    foreach (rnd_img[r, c]) rnd_img[r][c] = $urandom_range(255);

    repeat (2) @(negedge clk);
    check("rst_out_px", int'(bus.out_px_o), 0);
    check("rst_out_valid", int'(bus.out_valid_o), 0);
    check("rst_in_ready", int'(bus.in_ready_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    @(posedge clk); #1;
    nreset = 1'b1;

    run_frame(0, 1'b0, 0, 1'b0, 1'b0, W * H);   // flat
    run_frame(1, 1'b0, 0, 1'b0, 1'b0, W * H);   // vertical edge
    run_frame(2, 1'b1, 128, 1'b0, 1'b0, W * H); // ramp, below threshold
    run_frame(2, 1'b1, 80, 1'b0, 1'b0, W * H);  // ramp, at threshold
    run_frame(3, 1'b0, 0, 1'b0, 1'b1, W * H);   // backpressure

    run_frame(3, 1'b0, 0, 1'b0, 1'b0, W * H);
    first_seq = got_q;
    run_frame(3, 1'b0, 0, 1'b1, 1'b0, W * H);
    check("bubble_len", got_q.size(), first_seq.size());
    for (int i = 0; i < got_q.size() && i < first_seq.size(); i++)
      check("bubble_seq", got_q[i], first_seq[i]);

    run_frame(3, 1'b1, 100, 1'b0, 1'b0, 20);
    nreset = 1'b0;
    @(negedge clk);
    check("midrst_out_px", int'(bus.out_px_o), 0);
    check("midrst_out_valid", int'(bus.out_valid_o), 0);
    check("midrst_in_ready", int'(bus.in_ready_o), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    @(posedge clk); #1;
    nreset = 1'b1;
    run_frame(3, 1'b1, 100, 1'b1, 1'b0, W * H);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
